// File: rtl/keypad_scanner_if.sv
// Keypad scanner bus: matrix row/column lines plus the decoded-key outputs.
// master = scanner side, slave = keypad/consumer side.
interface keypad_scanner_if;
  logic [3:0] row_n;
  logic [3:0] col_n;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  modport master (input row_n, output col_n, output key_code, output key_valid, output key_held);
  modport slave  (output row_n, input col_n, input key_code, input key_valid, input key_held);
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column scan, press/release debounce, hex decode.
// Optional auto-repeat while a key is held is enabled by defining KEYPAD_REPEAT_EN.
module keypad_scanner #(
  parameter int unsigned SCAN_DIV        = 1000,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned REPEAT_CYCLES   = 500000
) (
  input  logic             clk,
  input  logic             reset_n,
  keypad_scanner_if.master kp
);

  localparam int unsigned DIV_W = $clog2(SCAN_DIV) + 1;
  localparam int unsigned DB_W  = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

  state_t           state;
  logic [3:0]       sync1;
  logic [3:0]       row_s;
  logic [3:0]       act;
  logic [1:0]       col;
  logic [1:0]       row;
  logic [DIV_W-1:0] dwell;
  logic [DB_W-1:0]  db_cnt;
  logic [3:0]       col_n_q;
  logic [3:0]       key_code_q;
  logic             key_valid_q;
  logic             key_held_q;

`ifdef KEYPAD_REPEAT_EN
  localparam int unsigned REP_W = $clog2(REPEAT_CYCLES) + 1;
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);
  logic [REP_W-1:0] rep_cnt;
`else
  logic unused_repeat;
  assign unused_repeat = |32'(REPEAT_CYCLES);
`endif

  assign act = ~row_s;

  // Lowest-index active row wins when several keys share the column.
  function automatic logic [1:0] low_row(input logic [3:0] a);
    if (a[0])      return 2'd0;
    else if (a[1]) return 2'd1;
    else if (a[2]) return 2'd2;
    else           return 2'd3;
  endfunction

  function automatic logic [3:0] key_map(input logic [1:0] c, input logic [1:0] r);
    case ({c, r})
      4'h0: return 4'hA;  4'h1: return 4'h7;  4'h2: return 4'h4;  4'h3: return 4'h1;
      4'h4: return 4'h0;  4'h5: return 4'h8;  4'h6: return 4'h5;  4'h7: return 4'h2;
      4'h8: return 4'hB;  4'h9: return 4'h9;  4'hA: return 4'h6;  4'hB: return 4'h3;
      4'hC: return 4'hF;  4'hD: return 4'hE;  4'hE: return 4'hD;  default: return 4'hC;
    endcase
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= SCAN;
      sync1       <= 4'hF;
      row_s       <= 4'hF;
      col         <= 2'd0;
      row         <= 2'd0;
      dwell       <= '0;
      db_cnt      <= '0;
      col_n_q     <= 4'b1110;
      key_code_q  <= 4'h0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt     <= '0;
`endif
    end else begin
      sync1       <= kp.row_n;
      row_s       <= sync1;
      key_valid_q <= 1'b0;
      case (state)
        SCAN: begin
          if (dwell == DIV_LAST) begin
            dwell <= '0;
            if (|act) begin
              row    <= low_row(act);
              db_cnt <= '0;
              state  <= DEBOUNCE;
            end else begin
              col     <= col + 2'd1;
              col_n_q <= {col_n_q[2:0], col_n_q[3]};
            end
          end else begin
            dwell <= dwell + DIV_W'(1);
          end
        end
        DEBOUNCE: begin
          if (!act[row]) begin
            db_cnt  <= '0;
            col     <= col + 2'd1;
            col_n_q <= {col_n_q[2:0], col_n_q[3]};
            state   <= SCAN;
          end else if (db_cnt == DB_LAST) begin
            db_cnt      <= '0;
            key_code_q  <= key_map(col, row);
            key_valid_q <= 1'b1;
            key_held_q  <= 1'b1;
            state       <= HELD;
`ifdef KEYPAD_REPEAT_EN
            rep_cnt     <= '0;
`endif
          end else begin
            db_cnt <= db_cnt + DB_W'(1);
          end
        end
        HELD: begin
          // Column stays frozen; only the latched row matters here.
          if (!act[row]) begin
            db_cnt <= '0;
            state  <= RELEASE;
          end
`ifdef KEYPAD_REPEAT_EN
          else if (rep_cnt == REP_LAST) begin
            rep_cnt     <= '0;
            key_valid_q <= 1'b1;
          end else begin
            rep_cnt <= rep_cnt + REP_W'(1);
          end
`endif
        end
        RELEASE: begin
          if (act[row]) begin
            db_cnt <= '0;
            state  <= HELD;
`ifdef KEYPAD_REPEAT_EN
            rep_cnt <= '0;
`endif
          end else if (db_cnt == DB_LAST) begin
            db_cnt     <= '0;
            dwell      <= '0;
            key_held_q <= 1'b0;
            col        <= col + 2'd1;
            col_n_q    <= {col_n_q[2:0], col_n_q[3]};
            state      <= SCAN;
          end else begin
            db_cnt <= db_cnt + DB_W'(1);
          end
        end
        default: state <= SCAN;
      endcase
    end
  end

  assign kp.col_n     = col_n_q;
  assign kp.key_code  = key_code_q;
  assign kp.key_valid = key_valid_q;
  assign kp.key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a keypad matrix model and a strobe scoreboard.
module tb_keypad_scanner;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  keypad_scanner_if kp ();

  keypad_scanner #(
    .SCAN_DIV       (4),
    .DEBOUNCE_CYCLES(8),
    .REPEAT_CYCLES  (32)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .kp     (kp)
  );

  // pressed[col][row]: a pressed key pulls its row low while its column is driven low.
  logic [3:0] pressed [4] = '{default: 4'h0};
  logic [3:0] row_drv;

  always_comb begin
    row_drv = 4'hF;
    for (int c = 0; c < 4; c++)
      if (!kp.col_n[c]) row_drv = row_drv & ~pressed[c];
  end
  assign kp.row_n = row_drv;

  int compared   = 0;
  int mismatched = 0;
  logic [3:0] exp_q [$];

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic key_dn(input int c, input int r);
    pressed[c][r] = 1'b1;
  endtask

  task automatic key_up(input int c, input int r);
    pressed[c][r] = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Every strobe must match the oldest expected code; unexpected strobes compare against EE.
  always @(negedge clk) begin
    if (reset_n && kp.key_valid) begin
      logic [7:0] want;
      want = (exp_q.size() != 0) ? 8'(exp_q.pop_front()) : 8'hEE;
      chk("strobe_code", 8'(kp.key_code), want);
    end
  end

  logic [3:0] col_seq [5] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
  logic [3:0] col_snap;
  logic       changed;
  logic       dropped;
  logic       seen;

  initial begin
    // Reset asserted mid-scan
    cycles(3);
    reset_n = 1'b1;
    cycles(6);
    reset_n = 1'b0;
    #1;
    chk("rst_col_n", 8'(kp.col_n), 8'h0E);
    chk("rst_key_code", 8'(kp.key_code), 8'h00);
    chk("rst_key_valid", 8'(kp.key_valid), 8'h00);
    chk("rst_key_held", 8'(kp.key_held), 8'h00);
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (k != 0) cycles(4);
      chk($sformatf("scan_col_%0d", k), 8'(kp.col_n), 8'(col_seq[k]));
    end

    // Bouncy press of key 5 (col1,row2)
    for (int b = 0; b < 3; b++) begin
      key_dn(1, 2); cycles(1);
      key_up(1, 2); cycles(1);
    end
    exp_q.push_back(4'h5);
    key_dn(1, 2);
    cycles(40);
    chk("bounce_held", 8'(kp.key_held), 8'h01);
    chk("bounce_q_empty", 8'(exp_q.size()), 8'h00);
    key_up(1, 2);
    cycles(9);
    chk("bounce_held_during_rel", 8'(kp.key_held), 8'h01);
    cycles(5);
    chk("bounce_held_fall", 8'(kp.key_held), 8'h00);
    chk("bounce_code_kept", 8'(kp.key_code), 8'h05);

    // Glitch on key 7 (col0,row1)
    key_dn(0, 1);
    cycles(5);
    key_up(0, 1);
    cycles(30);
    chk("glitch_held", 8'(kp.key_held), 8'h00);
    col_snap = kp.col_n;
    changed  = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cycles(1);
      if (kp.col_n != col_snap) changed = 1'b1;
    end
    chk("glitch_scan_resumes", 8'(changed), 8'h01);

    // Lockout: hold 1 (col0,row3), then press 9 (col2,row1)
    exp_q.push_back(4'h1);
    key_dn(0, 3);
    cycles(40);
    chk("lock_first_held", 8'(kp.key_held), 8'h01);
    key_dn(2, 1);
    cycles(40);
    chk("lock_col_frozen", 8'(kp.col_n), 8'h0E);
    chk("lock_code_1", 8'(kp.key_code), 8'h01);
    exp_q.push_back(4'h9);
    key_up(0, 3);
    cycles(40);
    chk("lock_q_empty", 8'(exp_q.size()), 8'h00);
    chk("lock_code_9", 8'(kp.key_code), 8'h09);
    chk("lock_second_held", 8'(kp.key_held), 8'h01);
    key_up(2, 1);
    cycles(20);
    chk("lock_released", 8'(kp.key_held), 8'h00);

    // Release bounce on key 2 (col1,row3): row returns at release count ~5
    exp_q.push_back(4'h2);
    key_dn(1, 3);
    cycles(40);
    chk("rb_held", 8'(kp.key_held), 8'h01);
    key_up(1, 3);
    dropped = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cycles(1);
      if (!kp.key_held) dropped = 1'b1;
    end
    key_dn(1, 3);
    for (int i = 0; i < 20; i++) begin
      cycles(1);
      if (!kp.key_held) dropped = 1'b1;
    end
    chk("rb_held_stays", 8'(dropped), 8'h00);
    chk("rb_q_empty", 8'(exp_q.size()), 8'h00);
    key_up(1, 3);
    cycles(20);
    chk("rb_released", 8'(kp.key_held), 8'h00);

    // Hold F (col3,row0) for 100 cycles after the first strobe
    exp_q.push_back(4'hF);
`ifdef KEYPAD_REPEAT_EN
    for (int i = 0; i < 3; i++) exp_q.push_back(4'hF);
`endif
    key_dn(3, 0);
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      cycles(1);
      seen = kp.key_valid;
    end
    chk("rep_first_strobe_seen", 8'(seen), 8'h01);
    cycles(100);
    key_up(3, 0);
    cycles(20);
    chk("rep_q_empty", 8'(exp_q.size()), 8'h00);
    chk("rep_code", 8'(kp.key_code), 8'h0F);
    chk("rep_released", 8'(kp.key_held), 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Scans the 4x4 matrix keypad by driving one column low at a time and reading the four active-low row lines through a two-flop synchronizer. Presses and releases are debounced, and a debounced press is translated into a 4-bit hex key code. Only one key is registered at a time. The block produces a one-cycle `key_valid` strobe with `key_code`, which the downstream display/shift logic consumes, plus a `key_held` level.

## Interface
Parameters:
- `SCAN_DIV`, 1000: clock cycles each column is driven before sampling; must be ≥ 3.
- `DEBOUNCE_CYCLES`, 50000: consecutive stable cycles required to accept a press or a release.
- `REPEAT_CYCLES`, 500000: auto-repeat period; used only with `KEYPAD_REPEAT_EN`.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: system clock.
- `reset_n` in 1: asynchronous active-low reset.
- `row_n` in 4: keypad rows, asynchronous, pulled up, low = pressed.
- `col_n` out 4: column drive, one-hot low.
- `key_code` out 4: hex code of the last accepted key.
- `key_valid` out 1: one-cycle strobe, new key accepted.
- `key_held` out 1: high while the accepted key is still down.

## Operation
- Synchronizer: `row_n` passes through 2 flops to give `row_s`; `act = ~row_s`.
- Reset values: `col_n`=4'b1110 (column 0), `key_code`=0, `key_valid`=0, `key_held`=0, state SCAN, all counters 0, synchronizer flops 4'b1111.
- Key map (col,row → code):
  - col0: A,7,4,1
  - col1: 0,8,5,2
  - col2: B,9,6,3
  - col3: F,E,D,C
- SCAN:
  - The dwell counter runs 0..SCAN_DIV-1. At SCAN_DIV-1 the block samples `act`.
  - If any row is active, it latches the column and the lowest-index active row, then goes to DEBOUNCE with the column held.
  - Otherwise it advances to the next column (3 wraps to 0) and clears the counter.
- DEBOUNCE:
  - The counter increments each cycle the latched row is active.
  - If the latched row is inactive on any cycle, the block returns to SCAN, advances the column, and emits no strobe.
  - When the count reaches DEBOUNCE_CYCLES, `key_code` is loaded from the map, `key_valid` pulses, `key_held` is set, and the state goes to HELD.
- HELD:
  - The column stays frozen, and every row other than the latched one is ignored.
  - When the latched row goes inactive, the state goes to RELEASE with the counter cleared.
- RELEASE:
  - The counter increments while the latched row is inactive.
  - If the row reactivates, the counter clears and the state returns to HELD with no strobe.
  - When the count reaches DEBOUNCE_CYCLES, `key_held` is cleared, the state goes to SCAN, the column advances, and the dwell counter clears.
- Simultaneous presses:
  - Keys in the same column: the lowest row wins.
  - A key in another column pressed while holding: ignored until release completes, then detected by normal scanning.
- `key_code` holds its value between strobes. `reset_n` low at any time returns immediately to the reset values.

## Timing
- Entering DEBOUNCE at cycle t with the row stable: `key_valid`=1 exactly at cycle t+DEBOUNCE_CYCLES, for one cycle. `key_code` is valid in the same cycle and remains valid afterward.
- Press-to-strobe latency: ≤ 2 (sync) + 4·SCAN_DIV + DEBOUNCE_CYCLES + 1 cycles.
- `key_held` rises together with `key_valid`. It falls DEBOUNCE_CYCLES cycles after the first synchronized-inactive cycle of an uninterrupted release.
- `col_n` changes only on SCAN column advance and never while in DEBOUNCE, HELD, or RELEASE.
- Counter widths are `$clog2` of each parameter plus 1, with no wrap.

## Configuration
Macro `KEYPAD_REPEAT_EN`:
- Defined: in HELD, a repeat counter, cleared on entry to HELD, pulses `key_valid` with an unchanged `key_code` every REPEAT_CYCLES cycles. The counter also clears on a RELEASE→HELD bounce.
- Undefined: the repeat counter and logic are absent. Exactly one `key_valid` is emitted per accepted press. `REPEAT_CYCLES` is ignored.

## Test plan
Bench parameters: SCAN_DIV=4, DEBOUNCE_CYCLES=8, REPEAT_CYCLES=32.
- Reset: assert `reset_n`=0 mid-scan → `col_n`=1110, `key_code`=0, `key_valid`=0, `key_held`=0. After release, columns cycle 1110→1101→1011→0111 every 4 cycles.
- Bouncy press: key 5 (col1,row2) toggles 3 times, then holds 40 cycles → exactly one `key_valid` with `key_code`=5, and `key_held`=1 until 8 cycles after the synchronized release.
- Glitch: key 7 pressed for 5 cycles → no `key_valid`, `key_held` stays 0, scanning resumes.
- Lockout: hold 1, then press 9; release 1 while 9 is held → first strobe code 1, no strobe while 1 is held, then after release debounce a second strobe with code 9.
- Release bounce: in RELEASE, reassert the row at count 5 → return to HELD, no extra strobe, `key_held` stays 1.
- `KEYPAD_REPEAT_EN`: hold F for 100 cycles after the first strobe → 1+3 strobes, all with code F. Without the macro → 1 strobe.
